// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access widths, FSM states and
// the alignment rule applied to every incoming request.
package lsu_pkg;

  // req_op[1:0] width encoding; any value with bit 1 set is a word access.
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EXT,
    S_WR,
    S_RMW
  } lsu_state_t;

  // Halfwords need an even byte address, words a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    if ((width & W_WORD) != 2'b00) bad = (lane != 2'b00);
    else if (width == W_HALF)      bad = lane[0];
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word and
// merges store data into a memory word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it to a full word (op[2] = unsigned).
  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op[1:0])
      W_BYTE:  load_data = op[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      W_HALF:  load_data = op[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Replace only the addressed lane of the old word with the new store data.
  always_comb begin
    store_data = rdata;
    case (op[1:0])
      W_BYTE: begin
        case (lane)
          2'd0:    store_data[7:0]   = wdata[7:0];
          2'd1:    store_data[15:8]  = wdata[7:0];
          2'd2:    store_data[23:16] = wdata[7:0];
          default: store_data[31:24] = wdata[7:0];
        endcase
      end
      W_HALF: begin
        if (lane[1]) store_data[31:16] = wdata[15:0];
        else         store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a single-port word-addressed data
// memory with registered read data and no byte enables. Sub-word stores are
// done as read-modify-write.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, and req_* are ignored at every other time.
// resp_valid is a single-cycle pulse with no backpressure; resp_misalign and
// resp_rdata are meaningful only while resp_valid is high.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misalign,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  lsu_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            lane_q;
  logic [2:0]            op_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  // Address bits above the memory size wrap and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  lsu_lane_align u_align (
    .rdata      (mem_out),
    .lane       (lane_q),
    .op         (op_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (merge_data)
  );

  // Memory port decode; mem_we depends only on the async-reset state register
  // so asserting reset drops the write enable immediately.
  assign req_ready   = (state == S_IDLE);
  assign mem_address = addr_q;
  assign mem_we      = (state == S_WR) || (state == S_RMW);
  assign mem_in      = (state == S_RMW) ? merge_data : wdata_q;

  // Request capture, sequencing and registered response generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      lane_q        <= '0;
      op_q          <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[ADDR_WIDTH+1:2];
            lane_q  <= req_addr[1:0];
            op_q    <= req_op;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            if (is_misaligned(req_op[1:0], req_addr[1:0])) begin
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_rdata    <= '0;
            end else if (req_we && req_op[1]) begin
              state <= S_WR;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: state <= we_q ? S_RMW : S_EXT;
        S_EXT: begin
          resp_valid    <= 1'b1;
          resp_misalign <= 1'b0;
          resp_rdata    <= load_data;
          state         <= S_IDLE;
        end
        S_WR, S_RMW: begin
          resp_valid    <= 1'b1;
          resp_misalign <= 1'b0;
          resp_rdata    <= '0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a behavioural data memory, a byte-array
// reference model, directed scenarios and a randomized back-to-back run.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic [9:0]  mem_address;
  logic [31:0] mem_in;
  logic        mem_we;
  logic [31:0] mem_out;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .mem_address   (mem_address),
    .mem_in        (mem_in),
    .mem_we        (mem_we),
    .mem_out       (mem_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port memory, registered read data
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (mem_we) mem[mem_address] <= mem_in;
    mem_out <= mem[mem_address];
  end

  // reference model: flat little-endian byte array, 4 KiB, addresses wrap
  logic [7:0] ref_bytes [4096];

  function automatic int ref_size(input logic [2:0] op);
    return op[1] ? 4 : (op[0] ? 2 : 1);
  endfunction

  function automatic logic ref_mis(input logic [2:0] op, input logic [31:0] addr);
    return (int'(addr[11:0]) % ref_size(op)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
    int     size;
    int     base;
    longint v;
    size = ref_size(op);
    base = int'(addr[11:0]);
    v = 0;
    for (int i = 0; i < size; i++) v += longint'(ref_bytes[base + i]) << (8 * i);
    if (!op[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int base;
    base = int'(addr[11:0]) & ~3;
    return {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    int base;
    base = int'(addr[11:0]);
    for (int i = 0; i < ref_size(op); i++) ref_bytes[base + i] = data[8*i +: 8];
  endtask

  // driver: called at a negedge; drives one request, returns response info
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic ready, output logic [31:0] rdata,
                       output logic mis, output int lat, output int wes, output logic [31:0] win);
    ready     = req_ready;
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0; wes = 0; win = '0; rdata = '0; mis = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (mem_we) begin
        wes++;
        win = mem_in;
      end
      if (resp_valid) begin
        lat   = n;
        rdata = resp_rdata;
        mis   = resp_misalign;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else n_pass++;
    n_checks++; if (resp_misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", resp_misalign); else n_pass++;
    n_checks++; if (mem_address !== 10'h0) $display("FAIL reset_mem_address: got %h want 0", mem_address); else n_pass++;
    n_checks++; if (mem_in !== 32'h0) $display("FAIL reset_mem_in: got %h want 0", mem_in); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_and_loads;
    logic        rdy, mis;
    logic [31:0] rd, win;
    int          lat, wes;
    logic [2:0]  ops   [5] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101};
    logic [31:0] addrs [5] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h2};
    logic [31:0] exps  [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_007F, 32'hFFFF_8000, 32'h0000_8000};
    issue(1'b1, 3'b010, 32'h0, 32'h8000_7FFF, rdy, rd, mis, lat, wes, win);
    ref_store(3'b010, 32'h0, 32'h8000_7FFF);
    n_checks++; if (lat !== 2) $display("FAIL sw_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (wes !== 1 || win !== 32'h8000_7FFF) $display("FAIL sw_write: got %0d pulses data %h want 1 pulse 80007fff", wes, win); else n_pass++;
    n_checks++; if (rd !== 32'h0 || mis !== 1'b0) $display("FAIL sw_resp: got rdata %h mis %b want 0 0", rd, mis); else n_pass++;
    issue(1'b0, 3'b010, 32'h0, 32'h0, rdy, rd, mis, lat, wes, win);
    n_checks++; if (lat !== 3) $display("FAIL lw_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (rd !== 32'h8000_7FFF) $display("FAIL lw_data: got %h want 80007fff", rd); else n_pass++;
    n_checks++; if (wes !== 0) $display("FAIL lw_no_write: got %0d pulses want 0", wes); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, ops[i], addrs[i], 32'h0, rdy, rd, mis, lat, wes, win);
      n_checks++; if (rd !== exps[i] || lat !== 3) $display("FAIL subword_load_%0d: got %h lat %0d want %h lat 3", i, rd, lat, exps[i]); else n_pass++;
    end
  endtask

  task automatic test_rmw;
    logic        rdy, mis;
    logic [31:0] rd, win;
    int          lat, wes;
    issue(1'b1, 3'b000, 32'h3, 32'h0000_AB12, rdy, rd, mis, lat, wes, win);
    ref_store(3'b000, 32'h3, 32'h0000_AB12);
    n_checks++; if (wes !== 1 || win !== 32'h1200_7FFF) $display("FAIL sb_rmw_write: got %0d pulses data %h want 1 pulse 12007fff", wes, win); else n_pass++;
    n_checks++; if (lat !== 3) $display("FAIL sb_latency: got %0d want 3", lat); else n_pass++;
    issue(1'b0, 3'b010, 32'h0, 32'h0, rdy, rd, mis, lat, wes, win);
    n_checks++; if (rd !== 32'h1200_7FFF) $display("FAIL sb_readback: got %h want 12007fff", rd); else n_pass++;
    issue(1'b1, 3'b001, 32'h0, 32'h0000_5555, rdy, rd, mis, lat, wes, win);
    ref_store(3'b001, 32'h0, 32'h0000_5555);
    n_checks++; if (wes !== 1 || win !== 32'h1200_5555) $display("FAIL sh_rmw_write: got %0d pulses data %h want 1 pulse 12005555", wes, win); else n_pass++;
    issue(1'b0, 3'b010, 32'h0, 32'h0, rdy, rd, mis, lat, wes, win);
    n_checks++; if (rd !== 32'h1200_5555) $display("FAIL sh_readback: got %h want 12005555", rd); else n_pass++;
  endtask

  task automatic test_misaligned;
    logic        rdy, mis;
    logic [31:0] rd, win;
    int          lat, wes;
    logic        wes_v [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  ops   [3] = '{3'b010, 3'b001, 3'b010};
    logic [31:0] addrs [3] = '{32'h6, 32'h1, 32'h2};
    for (int i = 0; i < 3; i++) begin
      issue(wes_v[i], ops[i], addrs[i], 32'hFFFF_FFFF, rdy, rd, mis, lat, wes, win);
      n_checks++;
      if (lat !== 1 || mis !== 1'b1 || rd !== 32'h0 || wes !== 0)
        $display("FAIL misaligned_%0d: got lat %0d mis %b rdata %h writes %0d want 1 1 0 0", i, lat, mis, rd, wes);
      else n_pass++;
    end
    issue(1'b0, 3'b010, 32'h0, 32'h0, rdy, rd, mis, lat, wes, win);
    n_checks++; if (rd !== ref_word(32'h0)) $display("FAIL misaligned_untouched: got %h want %h", rd, ref_word(32'h0)); else n_pass++;
  endtask

  task automatic test_alias;
    logic        rdy, mis;
    logic [31:0] rd, win;
    int          lat, wes;
    issue(1'b1, 3'b010, 32'h1000, 32'hDEAD_BEEF, rdy, rd, mis, lat, wes, win);
    ref_store(3'b010, 32'h1000, 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, 32'h0, 32'h0, rdy, rd, mis, lat, wes, win);
    n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL alias_wrap: got %h want deadbeef", rd); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic        rdy, mis;
    logic [31:0] rd, win;
    int          lat, wes;
    issue(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, rdy, rd, mis, lat, wes, win);
    ref_store(3'b010, 32'h10, 32'hCAFE_F00D);
    issue(1'b0, 3'b101, 32'h12, 32'h0, rdy, rd, mis, lat, wes, win);
    n_checks++; if (rdy !== 1'b1) $display("FAIL b2b_ready_in_resp_cycle: got %b want 1", rdy); else n_pass++;
    n_checks++; if (rd !== 32'h0000_CAFE || lat !== 3) $display("FAIL b2b_lhu: got %h lat %0d want 0000cafe lat 3", rd, lat); else n_pass++;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL resp_one_cycle: got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_random;
    logic        rdy, mis, we, exp_mis;
    logic [2:0]  op;
    logic [31:0] addr, data, rd, win, exp_rd, exp_win;
    int          lat, wes, exp_lat;
    for (int t = 0; t < 300; t++) begin
      we   = 1'($urandom);
      op   = 3'($urandom_range(0, 7));
      addr = {18'($urandom), 2'($urandom), 12'($urandom_range(0, 63))};
      data = $urandom;
      exp_mis = ref_mis(op, addr);
      exp_rd  = (we || exp_mis) ? 32'h0 : ref_load(op, addr);
      exp_lat = exp_mis ? 1 : ((we && ref_size(op) == 4) ? 2 : 3);
      if (we && !exp_mis) ref_store(op, addr, data);
      exp_win = ref_word(addr);
      issue(we, op, addr, data, rdy, rd, mis, lat, wes, win);
      n_checks++;
      if (rdy !== 1'b1 || lat !== exp_lat || mis !== exp_mis || rd !== exp_rd)
        $display("FAIL random_%0d resp: got rdy %b lat %0d mis %b rdata %h want 1 %0d %b %h (we %b op %b addr %h)",
                 t, rdy, lat, mis, rd, exp_lat, exp_mis, exp_rd, we, op, addr);
      else n_pass++;
      if (we && !exp_mis) begin
        n_checks++;
        if (wes !== 1 || win !== exp_win) $display("FAIL random_%0d write: got %0d pulses data %h want 1 pulse %h", t, wes, win, exp_win);
        else n_pass++;
      end else begin
        n_checks++;
        if (wes !== 0) $display("FAIL random_%0d nowrite: got %0d pulses want 0", t, wes); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_op;
    logic        rdy, mis, seen;
    logic [31:0] rd, win;
    int          lat, wes;
    issue(1'b1, 3'b010, 32'h4, 32'h1122_3344, rdy, rd, mis, lat, wes, win);
    ref_store(3'b010, 32'h4, 32'h1122_3344);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000; req_addr = 32'h7; req_wdata = 32'h0000_0099;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0 ||
        resp_misalign !== 1'b0 || mem_address !== 10'h0 || mem_in !== 32'h0)
      $display("FAIL midop_reset_outputs: got we %b rv %b rdy %b rd %h mis %b addr %h in %h want 0 0 1 0 0 0 0",
               mem_we, resp_valid, req_ready, resp_rdata, resp_misalign, mem_address, mem_in);
    else n_pass++;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (mem_we || resp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_we || resp_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL midop_no_activity: got %b want 0", seen); else n_pass++;
    issue(1'b0, 3'b010, 32'h4, 32'h0, rdy, rd, mis, lat, wes, win);
    n_checks++; if (rd !== 32'h1122_3344) $display("FAIL midop_word_unchanged: got %h want 11223344", rd); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = '0;
    mem_out = '0;
    test_reset();
    test_word_and_loads();
    test_rmw();
    test_misaligned();
    test_alias();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

CPU-side initiator for the single-port word-addressed data memory. Accepts byte-addressed load/store requests (byte, halfword, word; signed/unsigned loads), drives the memory's `address`/`in`/`we` port and consumes its registered read data. Sub-word stores use a read-modify-write sequence because the memory has no byte enables. Sits between the execute stage and the data memory.

## Interface
- `DATA_WIDTH`, 32, memory word width; fixed at 32 for byte-lane logic.
- `ADDR_WIDTH`, 10, memory word-address width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle, request accepted on `req_valid && req_ready` at the clock edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_op`  in  3  `[1:0]` width (00 byte, 01 half, 1x word); `[2]` unsigned (loads only, ignored on stores).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse, no backpressure.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_misalign`  out  1  qualifies `resp_valid`: request faulted, no memory access.
- `mem_address`  out  ADDR_WIDTH  word address to memory.
- `mem_in`  out  32  write data to memory.
- `mem_we`  out  1  memory write enable.
- `mem_out`  in  32  memory read data, valid the cycle after a non-write edge.

## Operation
- Word index = `req_addr[ADDR_WIDTH+1:2]`; upper bits ignored (addresses wrap modulo memory size). Lane k = `req_addr[1:0]`, little-endian: byte k at bits `[8k+7:8k]`, half at `[16h+15:16h]`, h = `addr[1]`.
- Misaligned: half with `addr[0]=1`, word with `addr[1:0]!=0`. Produces fault response, memory untouched.
- On accept, `addr_q`, `op_q`, `we_q`, `wdata_q` are registered; `mem_address = addr_q` word index at all times.
- FSM states: IDLE, RD, EXT, WR, RMW.
  - IDLE: `req_ready=1`. Accept → load: RD; SW: WR; SB/SH: RD; misaligned: stay IDLE, register fault response.
  - RD: `mem_we=0`; memory samples address at exit edge. → EXT (load) or RMW (store).
  - EXT: `resp_rdata <=` selected lane, sign-extended (op[2]=0) or zero-extended; `resp_valid<=1`. → IDLE.
  - WR: `mem_we=1`, `mem_in=wdata_q`; `resp_valid<=1`. → IDLE.
  - RMW: `mem_we=1`, `mem_in = mem_out` with target lane replaced by `wdata_q[7:0]`/`[15:0]`; `resp_valid<=1`. → IDLE.
- `mem_we` is high only in WR and RMW; `mem_in = wdata_q` outside RMW.

## Timing
- Accept at edge 0. Latency to `resp_valid` high: misaligned 1 cycle, SW 2, loads and SB/SH 3.
- `resp_valid` high exactly one cycle; the unit is back in IDLE with `req_ready=1` in that same cycle, so a new request may be accepted then.
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_misalign=0`, `mem_address=0`, `mem_in=0`, `mem_we=0`.
- Reset mid-operation aborts immediately. Reset during WR/RMW before the edge deasserts `mem_we` asynchronously, so no write occurs. No response is issued for the aborted request.
- `req_*` inputs are ignored outside IDLE.

## Structure
- Package `lsu_pkg`: width encodings (`W_BYTE`, `W_HALF`, `W_WORD`), state enum, misalignment function.
- One combinational sub-module `lsu_lane_align`: load lane extract plus sign/zero extension, and store lane merge. Shared by the EXT and RMW states.

## Test plan
- SW addr 0x0 data 0x80007FFF then LW 0x0 → `resp_rdata=0x80007FFF`; SW response 2 cycles after accept, LW response 3 cycles after accept.
- With word 0 = 0x80007FFF: LB 0x0 → 0xFFFFFFFF; LBU 0x0 → 0x000000FF; LB 0x1 → 0x0000007F; LH 0x2 → 0xFFFF8000; LHU 0x2 → 0x00008000.
- SB 0x3 data 0xAB12 → single `mem_we` pulse in RMW with `mem_in=0x12007FFF`; subsequent LW 0x0 → 0x12007FFF. SH 0x0 data 0x5555 → 0x12005555.
- LW 0x6, LH 0x1, SW 0x2 → each gives `resp_valid` 1 cycle after accept, `resp_misalign=1`, `resp_rdata=0`, and `mem_we` never high.
- SW 0x1000 data 0xDEADBEEF (ADDR_WIDTH=10) → aliases word 0; LW 0x0 → 0xDEADBEEF.
- Assert `rst_n=0` while in RD of an SB → `mem_we` stays 0, no `resp_valid`, all outputs at reset values. The memory word is unchanged when read back after reset.
